line_segment_feeder: RTL and testbench

//  Upstream stage of the line rasteriser. Accepts a stream of tracked pen points (x, y, pen-down flag),

---
 rtl/line_segment_feeder_pkg.sv | 27 ++
 rtl/line_segment_feeder_if.sv | 26 ++
 rtl/line_segment_feeder_point_fifo.sv | 55 +++++
 rtl/line_segment_feeder.sv | 135 +++++++++++++
 tb/tb_line_segment_feeder.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/line_segment_feeder_pkg.sv
// Shared types and constants for the line segment feeder.
package line_segment_feeder_pkg;

    localparam int unsigned COORD_W = 8;
    localparam int unsigned PT_W    = 2 * COORD_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECIDE = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    typedef struct packed {
        logic               pen;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } point_t;

    // Magnitude of a - b as a 9-bit signed difference (no coordinate wrap).
    function automatic logic [COORD_W:0] abs_diff(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
        logic signed [COORD_W:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return d[COORD_W] ? $unsigned(-d) : $unsigned(d);
    endfunction

endpackage

// File: rtl/line_segment_feeder_if.sv
// Point input and drawer handshake bundle.
interface line_segment_feeder_if;
    import line_segment_feeder_pkg::*;

    logic               pt_valid;
    logic [COORD_W-1:0] pt_x;
    logic [COORD_W-1:0] pt_y;
    logic               pt_pen;
    logic               pt_ready;
    logic               start;
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
    logic               done;

    modport slave (
        input  pt_valid, pt_x, pt_y, pt_pen, done,
        output pt_ready, start, x0, y0, x1, y1
    );

    modport master (
        output pt_valid, pt_x, pt_y, pt_pen, done,
        input  pt_ready, start, x0, y0, x1, y1
    );
endinterface

// File: rtl/line_segment_feeder_point_fifo.sv
// Small synchronous FIFO with an explicit occupancy count.
module point_fifo #(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned WIDTH = 17,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage, wrapping pointers and occupancy count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/line_segment_feeder.sv
// Turns buffered pen points into filtered line segments for the line drawer.
module line_segment_feeder
    import line_segment_feeder_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned MAX_JUMP       = 64,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                  clk,
    input  logic                  reset,
    line_segment_feeder_if.slave  bus,
    output logic                  busy,
    output logic                  timeout_err
);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    state_t             state;
    point_t             cur;
    point_t             head;
    logic [PT_W-1:0]    head_raw;
    logic [COORD_W-1:0] last_x;
    logic [COORD_W-1:0] last_y;
    logic               last_valid;
    logic [TO_W-1:0]    wait_cnt;
    logic               start;
    logic [COORD_W-1:0] x0, y0, x1, y1;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic               push;
    logic               pop;
    logic               same;
    logic               jump;

    assign bus.pt_ready = !fifo_full;
    assign push         = bus.pt_valid && !fifo_full;
    assign pop          = (state == ST_IDLE) && !fifo_empty;
    assign head         = point_t'(head_raw);
    assign busy         = (fifo_count != '0) || (state != ST_IDLE);
    assign bus.start    = start;
    assign bus.x0       = x0;
    assign bus.y0       = y0;
    assign bus.x1       = x1;
    assign bus.y1       = y1;

    point_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PT_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (PT_W'({bus.pt_pen, bus.pt_x, bus.pt_y})),
        .rdata (head_raw),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Filter terms for the point under decision against the last drawn endpoint.
    always_comb begin
        same = (cur.x == last_x) && (cur.y == last_y);
        jump = (abs_diff(cur.x, last_x) > (COORD_W + 1)'(MAX_JUMP)) ||
               (abs_diff(cur.y, last_y) > (COORD_W + 1)'(MAX_JUMP));
    end

    // Control FSM: pop, filter, issue segment, then wait for done or timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            cur         <= '0;
            last_x      <= '0;
            last_y      <= '0;
            last_valid  <= 1'b0;
            wait_cnt    <= '0;
            start       <= 1'b0;
            x0          <= '0;
            y0          <= '0;
            x1          <= '0;
            y1          <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        cur   <= head;
                        state <= ST_DECIDE;
                    end
                end
                ST_DECIDE: begin
                    if (!cur.pen) begin
                        last_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end else if (last_valid && same) begin
                        state <= ST_IDLE;
                    end else begin
                        if (last_valid && !jump) begin
                            x0 <= last_x;
                            y0 <= last_y;
                        end else begin
                            x0 <= cur.x;
                            y0 <= cur.y;
                        end
                        x1         <= cur.x;
                        y1         <= cur.y;
                        last_x     <= cur.x;
                        last_y     <= cur.y;
                        last_valid <= 1'b1;
                        start      <= 1'b1;
                        wait_cnt   <= '0;
                        state      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt != TO_W'(TIMEOUT_CYCLES)) begin
                        wait_cnt <= wait_cnt + TO_W'(1);
                    end
                    // done coinciding with the start pulse belongs to an earlier segment
                    if (start) begin
                        start <= 1'b0;
                    end else if (bus.done) begin
                        state <= ST_IDLE;
                    end else if (wait_cnt == TO_W'(TIMEOUT_CYCLES)) begin
                        timeout_err <= 1'b1;
                        last_valid  <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_line_segment_feeder.sv
// Randomized self-checking bench for line_segment_feeder.
module tb_line_segment_feeder;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned JUMP  = 64;
    localparam int unsigned TOUT  = 1023;

    logic clk = 1'b0;
    logic reset;
    logic busy;
    logic timeout_err;

    always #5 clk = ~clk;

    line_segment_feeder_if bus ();

    line_segment_feeder #(
        .FIFO_DEPTH     (DEPTH),
        .MAX_JUMP       (JUMP),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: last drawn endpoint.
    int m_lx = 0;
    int m_ly = 0;
    bit m_lv = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Returns 1 if the point must be drawn and gives the expected endpoints.
    function automatic bit predict(input int x, input int y, input bit pen,
                                   output int e0, output int e1, output int e2, output int e3);
        e0 = 0; e1 = 0; e2 = 0; e3 = 0;
        if (!pen) begin
            m_lv = 1'b0;
            return 1'b0;
        end
        if (m_lv && x == m_lx && y == m_ly) return 1'b0;
        if (m_lv && iabs(x - m_lx) <= int'(JUMP) && iabs(y - m_ly) <= int'(JUMP)) begin
            e0 = m_lx; e1 = m_ly;
        end else begin
            e0 = x; e1 = y;
        end
        e2 = x; e3 = y;
        m_lx = x; m_ly = y; m_lv = 1'b1;
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int x, input int y, input bit pen);
        int g = 0;
        while (bus.pt_ready !== 1'b1 && g < 2000) begin
            tick();
            g++;
        end
        check("push_ready", 32'(bus.pt_ready), 1);
        bus.pt_valid = 1'b1;
        bus.pt_x     = 8'(x);
        bus.pt_y     = 8'(y);
        bus.pt_pen   = pen;
        tick();
        bus.pt_valid = 1'b0;
    endtask

    task automatic wait_start(input string tag, input int e0, input int e1, input int e2, input int e3);
        int lat = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (bus.start === 1'b1) begin
                lat = i;
                break;
            end
        end
        check({tag, "_latency"}, 32'(lat), 2);
        check({tag, "_x0"}, 32'(bus.x0), 32'(e0));
        check({tag, "_y0"}, 32'(bus.y0), 32'(e1));
        check({tag, "_x1"}, 32'(bus.x1), 32'(e2));
        check({tag, "_y1"}, 32'(bus.y1), 32'(e3));
    endtask

    task automatic finish_seg(input string tag, input int e0, input int e1, input int e2, input int e3,
                              input int delay, input bit early, input bit idle_after);
        if (early) bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        check({tag, "_start_pulse"}, 32'(bus.start), 0);
        check({tag, "_still_busy"}, 32'(busy), 1);
        repeat (delay) tick();
        check({tag, "_hold"}, {bus.x0, bus.y0, bus.x1, bus.y1},
              {8'(e0), 8'(e1), 8'(e2), 8'(e3)});
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        if (idle_after) check({tag, "_idle"}, 32'(busy), 0);
    endtask

    task automatic expect_none(input string tag);
        bit saw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.start === 1'b1) saw = 1'b1;
            if (busy === 1'b0) break;
        end
        check({tag, "_no_start"}, 32'(saw), 0);
        check({tag, "_idle"}, 32'(busy), 0);
    endtask

    task automatic run_point(input string tag, input int x, input int y, input bit pen,
                             input int delay, input bit early);
        int e0, e1, e2, e3;
        bit draw;
        draw = predict(x, y, pen, e0, e1, e2, e3);
        push(x, y, pen);
        if (draw) begin
            wait_start(tag, e0, e1, e2, e3);
            finish_seg(tag, e0, e1, e2, e3, delay, early, 1'b1);
        end else begin
            expect_none(tag);
        end
    endtask

    function automatic int clamp(input int v);
        return (v < 0) ? 0 : ((v > 255) ? 255 : v);
    endfunction

    initial begin
        int px[6];
        int py[6];
        int e0, e1, e2, e3;
        int cnt;
        bit draw;

        reset        = 1'b1;
        bus.pt_valid = 1'b0;
        bus.pt_x     = '0;
        bus.pt_y     = '0;
        bus.pt_pen   = 1'b0;
        bus.done     = 1'b0;
        repeat (3) tick();
        check("rst_start", 32'(bus.start), 0);
        check("rst_endpoints", {bus.x0, bus.y0, bus.x1, bus.y1}, 0);
        check("rst_timeout", 32'(timeout_err), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ready", 32'(bus.pt_ready), 1);
        reset = 1'b0;
        tick();

        // First dot, then a segment with an early done that must be ignored.
        run_point("dot1", 10, 10, 1'b1, 5, 1'b0);
        run_point("seg1", 20, 15, 1'b1, 12, 1'b1);
        // Repeat skipped, pen lift, dot after lift.
        run_point("repeat", 20, 15, 1'b1, 0, 1'b0);
        run_point("penup", 30, 30, 1'b0, 0, 1'b0);
        run_point("dot2", 40, 40, 1'b1, 3, 1'b0);
        // Jump threshold around MAX_JUMP.
        run_point("lift0", 0, 0, 1'b0, 0, 1'b0);
        run_point("origin", 0, 0, 1'b1, 1, 1'b0);
        run_point("jump", 100, 5, 1'b1, 2, 1'b0);
        run_point("dx64", 36, 5, 1'b1, 2, 1'b0);
        run_point("dx65", 101, 5, 1'b1, 2, 1'b0);
        run_point("dy65", 101, 70, 1'b1, 2, 1'b0);

        // Random walk of points.
        for (int i = 0; i < 40; i++) begin
            int x, y, mode;
            bit pen;
            pen  = ($urandom_range(0, 7) != 0);
            mode = int'($urandom_range(0, 5));
            if (mode == 0 && m_lv) begin
                x = m_lx; y = m_ly;
            end else if (mode == 1) begin
                x = int'($urandom_range(0, 255)); y = int'($urandom_range(0, 255));
            end else begin
                x = clamp(m_lx + int'($urandom_range(0, 140)) - 70);
                y = clamp(m_ly + int'($urandom_range(0, 140)) - 70);
            end
            run_point("rand", x, y, pen, int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
        end

        // Stalled drawer: fill the FIFO, check back-pressure, then time out.
        for (int i = 0; i < 6; i++) begin
            px[i] = 50 + 3 * i;
            py[i] = 60 + 2 * i;
        end
        draw = predict(px[0], py[0], 1'b1, e0, e1, e2, e3);
        push(px[0], py[0], 1'b1);
        wait_start("stall0", e0, e1, e2, e3);
        for (int i = 1; i <= int'(DEPTH); i++) push(px[i], py[i], 1'b1);
        check("full_ready", 32'(bus.pt_ready), 0);
        bus.pt_valid = 1'b1;
        bus.pt_x     = 8'(px[5]);
        bus.pt_y     = 8'(py[5]);
        bus.pt_pen   = 1'b1;
        repeat (3) tick();
        check("full_ready_held", 32'(bus.pt_ready), 0);
        bus.pt_valid = 1'b0;
        check("timeout_early", 32'(timeout_err), 0);
        cnt = 0;
        while (timeout_err !== 1'b1 && cnt < 1100) begin
            tick();
            cnt++;
        end
        check("timeout_set", 32'(timeout_err), 1);
        check("timeout_window", 32'(cnt >= 1000 && cnt <= 1030), 1);
        m_lv = 1'b0;
        for (int i = 1; i <= int'(DEPTH); i++) begin
            draw = predict(px[i], py[i], 1'b1, e0, e1, e2, e3);
            wait_start("drain", e0, e1, e2, e3);
            finish_seg("drain", e0, e1, e2, e3, 1, 1'b0, (i == int'(DEPTH)));
        end
        run_point("after_stall", px[5], py[5], 1'b1, 2, 1'b0);
        check("timeout_sticky", 32'(timeout_err), 1);

        // Asynchronous reset while waiting with points buffered.
        draw = predict(120, 120, 1'b1, e0, e1, e2, e3);
        push(120, 120, 1'b1);
        wait_start("pre_reset", e0, e1, e2, e3);
        for (int i = 0; i < 3; i++) push(121 + i, 121, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("arst_start", 32'(bus.start), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_ready", 32'(bus.pt_ready), 1);
        check("arst_timeout", 32'(timeout_err), 0);
        check("arst_endpoints", {bus.x0, bus.y0, bus.x1, bus.y1}, 0);
        tick();
        reset = 1'b0;
        m_lv = 1'b0;
        tick();
        run_point("post_reset", 125, 121, 1'b1, 2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
